ahb_bram_ctrl: RTL
==================

# ahb_bram_ctrl

AHB-Lite slave controller that sequences the dual-port `Block_RAM` (write port A, registered-address read port B) as zero-wait-state code/data memory on the Cortex-M3 system bus. It tracks the AHB address and data phases and generates byte-lane write enables from `HSIZE`/`HADDR`. It forwards just-written bytes into a following read of the same word, and optionally returns two-cycle ERROR responses for illegal transfers.

## Interface
- `ADDR_WIDTH`, 14, word-address width of the attached RAM; byte space is 2^(ADDR_WIDTH+2) bytes.
- `HCLK`  in  1  system clock; also clocks the RAM.
- `HRESETn`  in  1  asynchronous active-low reset.
- `HSEL`  in  1  slave select.
- `HADDR`  in  32  byte address.
- `HTRANS`  in  2  transfer type; NONSEQ=2'b10, SEQ=2'b11 are active.
- `HSIZE`  in  3  0=byte, 1=half, 2=word.
- `HWRITE`  in  1  1=write.
- `HWDATA`  in  32  write data, valid in the data phase.
- `HREADY`  in  1  bus ready; an address phase is accepted only when this is 1.
- `HREADYOUT`  out  1  slave ready.
- `HRESP`  out  1  0=OKAY, 1=ERROR.
- `HRDATA`  out  32  read data.
- `BRAM_ADDRA`  out  ADDR_WIDTH  write word address.
- `BRAM_WEA`  out  4  byte write enables.
- `BRAM_DINA`  out  32  write data.
- `BRAM_ADDRB`  out  ADDR_WIDTH  read word address; the RAM registers it.
- `BRAM_DOUTB`  in  32  read data, valid the cycle after `BRAM_ADDRB` is sampled.

## Operation
- Transfer accepted when `HSEL & HREADY & HTRANS[1]`.
- Word address is `HADDR[ADDR_WIDTH+1:2]`. Upper bits are ignored, so accesses alias.
- Byte mask from the address phase:
  - byte: `4'b0001 << HADDR[1:0]`
  - half: `HADDR[1] ? 4'b1100 : 4'b0011`
  - word: `4'b1111`
- FSM states:
  - **IDLE**: no data phase pending.
  - **WR**: write data phase.
  - **RD**: read data phase.
  - **ERR1**: first error cycle.
  - **ERR2**: second error cycle.
- Transitions:
  - On an accepted transfer from IDLE, WR, RD or ERR2, go to WR or RD per `HWRITE`.
  - With no accepted transfer, go to IDLE.
  - An illegal transfer (see Configuration) goes to ERR1, then ERR2 unconditionally.
- Write: address, mask and word index are registered at the address phase. In WR, drive `BRAM_ADDRA` from the registered address, `BRAM_WEA` from the registered mask and `BRAM_DINA`=`HWDATA`. The RAM commits at the end of WR. Outside WR, `BRAM_WEA`=0.
- Read: `BRAM_ADDRB` is driven combinationally from `HADDR[ADDR_WIDTH+1:2]` every cycle. `HRDATA`=`BRAM_DOUTB` in RD and 0 in all other states. Full words are always returned; the master selects lanes.
- Forwarding: on the WR→RD edge, latch `HWDATA`, the mask and the write word address into a one-entry buffer. If the RD word address equals the buffered address, each masked byte of `HRDATA` comes from the buffer. The buffer is invalidated on any non-RD cycle. This makes read-after-write correct whether the inferred RAM is read-first or write-first.
- Back-to-back mixed WR/RD sequences are sustained at one transfer per cycle.

## Timing
- Reset values:
  - state IDLE
  - `HREADYOUT`=1
  - `HRESP`=0
  - `HRDATA`=0
  - `BRAM_WEA`=0
  - forwarding buffer invalid
  - registered address and mask 0
- Latency: zero wait states. Read data is valid in the cycle after the address phase. Write is committed at the edge ending the data phase.
- ERROR response:
  - ERR1: `HREADYOUT`=0, `HRESP`=1.
  - ERR2: `HREADYOUT`=1, `HRESP`=1.
  - No RAM write occurs for an erroneous transfer.
- IDLE/BUSY `HTRANS`, or `HSEL`=0, during an address phase produces no data phase and leaves `HREADYOUT`=1.
- `HREADY`=0 from another slave: address phase not sampled; state goes to IDLE after the current data phase.
- Reset mid-transfer: FSM returns to IDLE asynchronously, `BRAM_WEA` drops to 0 immediately and the pending write is lost.

## Configuration
- Macro `AHB_BRAM_CTRL_ALIGN_CHECK_EN`.
- Defined: a transfer is illegal, and takes the ERR1/ERR2 path, when any of these holds:
  - `HSIZE`>2
  - half-word access with `HADDR[0]`=1
  - word access with `HADDR[1:0]`≠0
- Not defined: no checks are made. `HRESP` is tied 0 and ERR states are unreachable. Oversize transfers are treated as word; misaligned low bits are ignored by the mask rules above (half uses `HADDR[1]` only, word uses `4'b1111`).

## Test plan
- Word write 0xDEADBEEF to 0x0000_0010, then idle, then read 0x10 → `BRAM_WEA`=4'hF, word 4 written, `HRDATA`=0xDEADBEEF, `HRESP`=0.
- Byte write 0xAA to 0x13 over an existing 0x11223344 → `BRAM_WEA`=4'b1000; a later read returns 0xAA223344.
- Half write 0x5566 to 0x20 immediately followed by a read of 0x20 (pipelined) over an existing 0xFFFFFFFF → `HRDATA`=0xFFFF5566 via forwarding, with no wait state.
- Alternating write/read to different words for 8 cycles → `HREADYOUT` constant 1; all read data matches the model.
- With the macro defined, word write to 0x02 → one cycle `HREADYOUT`=0/`HRESP`=1, then `HREADYOUT`=1/`HRESP`=1, `BRAM_WEA` never nonzero. Without the macro, the same transfer writes word 0 with OKAY.
- Assert `HRESETn` low during a WR phase → `BRAM_WEA`=0 immediately and the RAM word is unchanged; after release, state is IDLE and `HREADYOUT`=1.

Source files
------------

// File: rtl/ahb_bram_ctrl.sv
// ahb_bram_ctrl
// AHB-Lite slave that runs a dual-port block RAM as zero-wait-state memory.
// Port A is the write port. Port B is the read port, and the RAM registers its address.
//
// Optional feature: define AHB_BRAM_CTRL_ALIGN_CHECK_EN to reject oversize and
// misaligned transfers with a two-cycle ERROR response. When it is not defined,
// HRESP is tied to 0 and the error states cannot be reached.
//
// Ports:
//   HCLK, HRESETn           clock (also clocks the RAM), async active-low reset
//   HSEL, HADDR, HTRANS,    AHB address phase
//   HSIZE, HWRITE, HREADY
//   HWDATA                  AHB write data (data phase)
//   HREADYOUT, HRESP        slave ready / response
//   HRDATA                  read data (data phase)
//   BRAM_ADDRA/WEA/DINA     RAM write port
//   BRAM_ADDRB, BRAM_DOUTB  RAM read port (DOUTB valid one cycle after ADDRB)
//   dbg_state               current FSM state, for observation only
module ahb_bram_ctrl #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
  output logic [3:0]            BRAM_WEA,
  output logic [31:0]           BRAM_DINA,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
  input  logic [31:0]           BRAM_DOUTB,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                  state, state_n;
  logic                    accept;
  logic                    illegal;
  logic [3:0]              mask;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              mask_q;
  logic                    fwd_valid;
  logic [ADDR_WIDTH-1:0]   fwd_addr;
  logic [3:0]              fwd_mask;
  logic [31:0]             fwd_data;
  logic                    fwd_hit;
  logic                    unused_bits;

  // Handshake: an address phase is taken only when the bus says it is ready
  // (HREADY=1), this slave is selected, and HTRANS is NONSEQ or SEQ.
  // The data phase completes in the next cycle on any edge where HREADYOUT=1.
  assign accept    = HSEL & HREADY & HTRANS[1];
  assign word_addr = HADDR[ADDR_WIDTH+1:2];

  // Upper address bits alias; HTRANS[0] only distinguishes SEQ from NONSEQ.
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  always_comb begin
    mask = 4'b1111;
    case (HSIZE)
      3'd0:    mask = 4'b0001 << HADDR[1:0];
      3'd1:    mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

`ifdef AHB_BRAM_CTRL_ALIGN_CHECK_EN
  assign illegal = (HSIZE > 3'd2) ||
                   ((HSIZE == 3'd1) && HADDR[0]) ||
                   ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
`else
  assign illegal = 1'b0;
`endif

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next state: ERR1 always moves on to ERR2. Every other state, ERR2
  // included, can start a new data phase.
  always_comb begin
    state_n = S_IDLE;
    if (state == S_ERR1) begin
      state_n = S_ERR2;
    end else if (accept) begin
      if (illegal)     state_n = S_ERR1;
      else if (HWRITE) state_n = S_WR;
      else             state_n = S_RD;
    end
  end

  // The address-phase word and lane mask feed the next data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= '0;
      mask_q <= '0;
    end else if (accept && !illegal) begin
      addr_q <= word_addr;
      mask_q <= mask;
    end
  end

  // One-entry store buffer. It catches the write that immediately precedes a
  // read. At the edge that commits that write, the RAM samples the read address
  // too, so a read-first RAM would return stale data.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_mask  <= '0;
      fwd_data  <= '0;
    end else if ((state == S_WR) && (state_n == S_RD)) begin
      fwd_valid <= 1'b1;
      fwd_addr  <= addr_q;
      fwd_mask  <= mask_q;
      fwd_data  <= HWDATA;
    end else if (state != S_RD) begin
      fwd_valid <= 1'b0;
    end
  end

  assign fwd_hit = fwd_valid && (fwd_addr == addr_q);

  always_comb begin
    HRDATA = 32'h0;
    if (state == S_RD) begin
      for (int b = 0; b < 4; b++) begin
        HRDATA[8*b +: 8] = (fwd_hit && fwd_mask[b]) ? fwd_data[8*b +: 8]
                                                     : BRAM_DOUTB[8*b +: 8];
      end
    end
  end

  assign BRAM_ADDRA = addr_q;
  assign BRAM_DINA  = HWDATA;
  assign BRAM_WEA   = (state == S_WR) ? mask_q : 4'b0000;
  assign BRAM_ADDRB = word_addr;

  assign HREADYOUT = (state != S_ERR1);
`ifdef AHB_BRAM_CTRL_ALIGN_CHECK_EN
  assign HRESP = (state == S_ERR1) || (state == S_ERR2);
`else
  assign HRESP = 1'b0;
`endif

  assign dbg_state = state;

endmodule
